// File: rtl/reorder_buffer.sv
// In-order retirement buffer: 32 circular slots. Results arrive out of order on three
// broadcast buses, and at most one ready entry at the head is committed per cycle.
module reorder_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        hci_rdy,
  input  logic        in_en,
  input  logic [4:0]  in_rd,
  input  logic        in_ready,
  input  logic [31:0] in_val,
  output logic [4:0]  alloc_id,
  output logic        full,
  input  logic        writeback1_en,
  input  logic [4:0]  writeback1_vregid,
  input  logic [31:0] writeback1_val,
  input  logic        writeback2_en,
  input  logic [4:0]  writeback2_vregid,
  input  logic [31:0] writeback2_val,
  input  logic        writeback3_en,
  input  logic [4:0]  writeback3_vregid,
  input  logic [31:0] writeback3_val,
  input  logic [4:0]  query1_id,
  input  logic [4:0]  query2_id,
  output logic        query1_ready,
  output logic        query2_ready,
  output logic [31:0] query1_val,
  output logic [31:0] query2_val,
  input  logic        flush,
  output logic        commit_en,
  output logic [4:0]  commit_rd,
  output logic [4:0]  commit_vregid,
  output logic [31:0] commit_val
);

  logic [31:0] r_live;
  logic [31:0] r_ready;
  logic [4:0]  r_rd  [32];
  logic [31:0] r_val [32];
  logic [4:0]  r_head;
  logic [4:0]  r_tail;
  logic [5:0]  r_count;

  logic        w_alloc;
  logic        w_commit;
  logic [31:0] w_wb_hit;
  logic [31:0] w_wb_set;
  logic [31:0] w_wb_val [32];
  logic [31:0] w_live_nxt;
  logic [31:0] w_ready_nxt;
  logic [4:0]  w_qid  [2];
  logic        w_qrdy [2];
  logic [31:0] w_qval [2];

  assign alloc_id = r_tail;
  assign full     = (r_count >= 6'd30);
  assign w_alloc  = in_en && (r_count != 6'd32);
  // Commit looks only at registered state, so a writeback never bypasses into commit.
  assign w_commit = r_live[r_head] && r_ready[r_head];

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      w_wb_hit[i] = 1'b0;
      w_wb_val[i] = '0;
      if (writeback1_en && (writeback1_vregid == 5'(i))) begin
        w_wb_hit[i] = 1'b1;
        w_wb_val[i] = writeback1_val;
      end else if (writeback2_en && (writeback2_vregid == 5'(i))) begin
        w_wb_hit[i] = 1'b1;
        w_wb_val[i] = writeback2_val;
      end else if (writeback3_en && (writeback3_vregid == 5'(i))) begin
        w_wb_hit[i] = 1'b1;
        w_wb_val[i] = writeback3_val;
      end
    end
  end

  // The slot being allocated is never live, so stale broadcasts cannot mark it ready.
  assign w_wb_set = r_live & ~r_ready & w_wb_hit;

  always_comb begin
    w_live_nxt  = r_live;
    w_ready_nxt = r_ready | w_wb_set;
    if (w_commit) w_live_nxt[r_head] = 1'b0;
    if (w_alloc) begin
      w_live_nxt[r_tail]  = 1'b1;
      w_ready_nxt[r_tail] = in_ready;
    end
  end

  assign w_qid[0] = query1_id;
  assign w_qid[1] = query2_id;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      w_qrdy[k] = 1'b0;
      w_qval[k] = '0;
      if (r_ready[w_qid[k]]) begin
        w_qrdy[k] = 1'b1;
        w_qval[k] = r_val[w_qid[k]];
      end else if (writeback1_en && (writeback1_vregid == w_qid[k])) begin
        w_qrdy[k] = 1'b1;
        w_qval[k] = writeback1_val;
      end else if (writeback2_en && (writeback2_vregid == w_qid[k])) begin
        w_qrdy[k] = 1'b1;
        w_qval[k] = writeback2_val;
      end else if (writeback3_en && (writeback3_vregid == w_qid[k])) begin
        w_qrdy[k] = 1'b1;
        w_qval[k] = writeback3_val;
      end
    end
  end

  assign query1_ready = w_qrdy[0];
  assign query1_val   = w_qval[0];
  assign query2_ready = w_qrdy[1];
  assign query2_val   = w_qval[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_live        <= '0;
      r_ready       <= '0;
      commit_en     <= 1'b0;
      commit_rd     <= '0;
      commit_vregid <= '0;
      commit_val    <= '0;
    end else if (hci_rdy) begin
      if (flush) begin
        r_live    <= '0;
        r_head    <= '0;
        r_tail    <= '0;
        r_count   <= '0;
        commit_en <= 1'b0;
      end else begin
        r_live    <= w_live_nxt;
        r_ready   <= w_ready_nxt;
        r_head    <= r_head + 5'(w_commit);
        r_tail    <= r_tail + 5'(w_alloc);
        r_count   <= r_count + 6'(w_alloc) - 6'(w_commit);
        commit_en <= w_commit;
        if (w_commit) begin
          commit_rd     <= r_rd[r_head];
          commit_vregid <= r_head;
          commit_val    <= r_val[r_head];
        end
      end
    end
  end

  // Entry payload carries no reset; its liveness and readiness bits qualify it.
  always_ff @(posedge clk) begin
    if (hci_rdy && !flush) begin
      for (int i = 0; i < 32; i++) begin
        if (w_wb_set[i]) r_val[i] <= w_wb_val[i];
      end
      if (w_alloc) begin
        r_rd[r_tail]  <= in_rd;
        r_val[r_tail] <= in_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && hci_rdy && !flush && in_en)
      assert (r_count != 6'd32)
      else $fatal(1, "reorder_buffer: allocation attempted with all 32 slots in use");
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: ordering, query bypass, wrap, stall, flush and reset.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hci_rdy, in_en, in_ready, flush;
  logic [4:0]  in_rd;
  logic [31:0] in_val;
  logic [4:0]  alloc_id;
  logic        full;
  logic        wb1_en, wb2_en, wb3_en;
  logic [4:0]  wb1_id, wb2_id, wb3_id;
  logic [31:0] wb1_val, wb2_val, wb3_val;
  logic [4:0]  q1_id, q2_id;
  logic        q1_rdy, q2_rdy;
  logic [31:0] q1_val, q2_val;
  logic        commit_en;
  logic [4:0]  commit_rd, commit_vregid;
  logic [31:0] commit_val;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .hci_rdy(hci_rdy),
    .in_en(in_en), .in_rd(in_rd), .in_ready(in_ready), .in_val(in_val),
    .alloc_id(alloc_id), .full(full),
    .writeback1_en(wb1_en), .writeback1_vregid(wb1_id), .writeback1_val(wb1_val),
    .writeback2_en(wb2_en), .writeback2_vregid(wb2_id), .writeback2_val(wb2_val),
    .writeback3_en(wb3_en), .writeback3_vregid(wb3_id), .writeback3_val(wb3_val),
    .query1_id(q1_id), .query2_id(q2_id),
    .query1_ready(q1_rdy), .query2_ready(q2_rdy),
    .query1_val(q1_val), .query2_val(q2_val),
    .flush(flush),
    .commit_en(commit_en), .commit_rd(commit_rd),
    .commit_vregid(commit_vregid), .commit_val(commit_val)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_commit(input string tag, input int id, input int rd, input logic [31:0] val);
    chk({tag, ".en"},  32'(commit_en), 32'd1);
    chk({tag, ".vid"}, 32'(commit_vregid), 32'(id));
    chk({tag, ".rd"},  32'(commit_rd), 32'(rd));
    chk({tag, ".val"}, commit_val, val);
  endtask

  initial begin
    int id;
    hci_rdy = 1'b1; in_en = 1'b0; in_ready = 1'b0; flush = 1'b0;
    in_rd = '0; in_val = '0;
    wb1_en = 1'b0; wb2_en = 1'b0; wb3_en = 1'b0;
    wb1_id = '0; wb2_id = '0; wb3_id = '0;
    wb1_val = '0; wb2_val = '0; wb3_val = '0;
    q1_id = '0; q2_id = '0;

    // reset
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.alloc_id", 32'(alloc_id), 32'd0);
    chk("rst.full", 32'(full), 32'd0);
    chk("rst.commit_en", 32'(commit_en), 32'd0);
    chk("rst.commit_rd", 32'(commit_rd), 32'd0);
    chk("rst.commit_vid", 32'(commit_vregid), 32'd0);
    chk("rst.commit_val", commit_val, 32'd0);
    rst = 1'b0;

    // in-order commit: older not-ready entry blocks a younger ready one
    in_en = 1'b1; in_rd = 5'd5; in_ready = 1'b0;
    chk("order.alloc0", 32'(alloc_id), 32'd0);
    tick();
    in_rd = 5'd6; in_ready = 1'b1; in_val = 32'h22;
    chk("order.alloc1", 32'(alloc_id), 32'd1);
    tick();
    in_en = 1'b0; in_ready = 1'b0;
    wb2_en = 1'b1; wb2_id = 5'd0; wb2_val = 32'h11;
    tick();
    chk("order.no_early", 32'(commit_en), 32'd0);
    wb2_en = 1'b0;
    tick();
    chk_commit("order.c0", 0, 5, 32'h11);
    tick();
    chk_commit("order.c1", 1, 6, 32'h22);
    tick();
    chk("order.idle", 32'(commit_en), 32'd0);

    // ready-at-allocation into empty buffer commits after the second edge
    in_en = 1'b1; in_rd = 5'd7; in_ready = 1'b1; in_val = 32'h33;
    tick();
    in_en = 1'b0; in_ready = 1'b0;
    chk("lat.edge1", 32'(commit_en), 32'd0);
    tick();
    chk_commit("lat.edge2", 2, 7, 32'h33);
    tick();

    // query bypass from the writeback buses
    in_en = 1'b1; in_rd = 5'd8; in_ready = 1'b0;
    chk("qry.alloc3", 32'(alloc_id), 32'd3);
    tick();
    in_en = 1'b0;
    q2_id = 5'd10;
    #1;
    chk("qry.miss.rdy", 32'(q2_rdy), 32'd0);
    chk("qry.miss.val", q2_val, 32'd0);
    wb1_en = 1'b1; wb1_id = 5'd3; wb1_val = 32'hDEADBEEF;
    wb3_en = 1'b1; wb3_id = 5'd3; wb3_val = 32'h1;
    q1_id = 5'd3; q2_id = 5'd3;
    #1;
    chk("qry.byp.rdy", 32'(q1_rdy), 32'd1);
    chk("qry.byp.val", q1_val, 32'hDEADBEEF);
    chk("qry.prio.val", q2_val, 32'hDEADBEEF);
    tick();
    wb1_en = 1'b0; wb3_en = 1'b0;
    #1;
    chk("qry.stored.rdy", 32'(q1_rdy), 32'd1);
    chk("qry.stored.val", q1_val, 32'hDEADBEEF);
    tick();
    chk_commit("qry.commit", 3, 8, 32'hDEADBEEF);

    // stale broadcast to the slot being allocated is ignored; bus 2 beats bus 3
    in_en = 1'b1; in_rd = 5'd9; in_ready = 1'b0;
    wb1_en = 1'b1; wb1_id = 5'd4; wb1_val = 32'h55;
    tick();
    in_en = 1'b0; wb1_en = 1'b0; q1_id = 5'd4;
    #1;
    chk("stale.q_rdy", 32'(q1_rdy), 32'd0);
    tick();
    chk("stale.no_commit", 32'(commit_en), 32'd0);
    wb2_en = 1'b1; wb2_id = 5'd4; wb2_val = 32'h66;
    wb3_en = 1'b1; wb3_id = 5'd4; wb3_val = 32'h77;
    tick();
    wb2_en = 1'b0; wb3_en = 1'b0;
    tick();
    chk_commit("prio.commit", 4, 9, 32'h66);
    tick();

    // stall: nothing moves, broadcasts are lost
    in_en = 1'b1; in_rd = 5'd10; in_ready = 1'b0;
    tick();
    in_rd = 5'd11; hci_rdy = 1'b0;
    wb3_en = 1'b1; wb3_id = 5'd5; wb3_val = 32'h99;
    repeat (3) tick();
    chk("stall.alloc_id", 32'(alloc_id), 32'd6);
    chk("stall.commit_en", 32'(commit_en), 32'd0);
    chk("stall.full", 32'(full), 32'd0);
    hci_rdy = 1'b1; in_en = 1'b0; wb3_en = 1'b0;
    tick();
    tick();
    chk("stall.lost", 32'(commit_en), 32'd0);
    q1_id = 5'd5;
    #1;
    chk("stall.q_rdy", 32'(q1_rdy), 32'd0);
    wb1_en = 1'b1; wb1_id = 5'd5; wb1_val = 32'hAA;
    tick();
    wb1_en = 1'b0;
    tick();
    chk_commit("stall.c5", 5, 10, 32'hAA);
    hci_rdy = 1'b0;
    tick();
    tick();
    chk_commit("stall.hold", 5, 10, 32'hAA);
    chk("stall.hold_alloc", 32'(alloc_id), 32'd6);
    hci_rdy = 1'b1;
    tick();
    chk("stall.release", 32'(commit_en), 32'd0);

    // fill to 30, full flag, then simultaneous alloc+commit at 30
    in_en = 1'b1; in_ready = 1'b0;
    for (int n = 0; n < 30; n++) begin
      id = (6 + n) % 32;
      in_rd = 5'(id);
      chk("fill.alloc_id", 32'(alloc_id), 32'(id));
      if (n == 29) chk("fill.full29", 32'(full), 32'd0);
      tick();
    end
    in_en = 1'b0;
    chk("fill.full30", 32'(full), 32'd1);
    chk("fill.alloc4", 32'(alloc_id), 32'd4);
    wb1_en = 1'b1; wb1_id = 5'd6; wb1_val = 32'h206;
    tick();
    wb1_en = 1'b0;
    in_en = 1'b1; in_rd = 5'd4; in_ready = 1'b0;
    tick();
    in_en = 1'b0;
    chk_commit("simul.commit", 6, 6, 32'h206);
    chk("simul.full", 32'(full), 32'd1);
    chk("simul.alloc5", 32'(alloc_id), 32'd5);

    // retire all 30 in order, head wraps 31->0
    for (int k = 0; k < 30; k++) begin
      id = (7 + k) % 32;
      wb1_en = 1'b1; wb1_id = 5'(id); wb1_val = 32'h200 + 32'(id);
      tick();
      if (k > 0) begin
        id = (7 + k - 1) % 32;
        chk_commit("retire", id, id, 32'h200 + 32'(id));
      end
    end
    wb1_en = 1'b0;
    tick();
    chk_commit("retire.last", 4, 4, 32'h204);
    tick();
    chk("retire.idle", 32'(commit_en), 32'd0);
    chk("retire.full", 32'(full), 32'd0);

    // 40 ready allocations streaming through the wrap
    in_en = 1'b1; in_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      id = (5 + n) % 32;
      in_rd = 5'(id); in_val = 32'h3000 + 32'(n);
      chk("wrap.alloc_id", 32'(alloc_id), 32'(id));
      tick();
      if (n > 0) begin
        id = (5 + n - 1) % 32;
        chk_commit("wrap", id, id, 32'h3000 + 32'(n - 1));
      end
    end
    in_en = 1'b0; in_ready = 1'b0;
    tick();
    chk_commit("wrap.last", 12, 12, 32'h3027);
    tick();

    // flush with 10 live entries, overriding a same-cycle alloc and writeback
    in_en = 1'b1; in_ready = 1'b0;
    repeat (10) tick();
    in_ready = 1'b1; in_val = 32'h5; flush = 1'b1;
    wb1_en = 1'b1; wb1_id = 5'd13; wb1_val = 32'h5;
    tick();
    flush = 1'b0; in_en = 1'b0; in_ready = 1'b0; wb1_en = 1'b0;
    chk("flush.alloc_id", 32'(alloc_id), 32'd0);
    chk("flush.commit_en", 32'(commit_en), 32'd0);
    chk("flush.full", 32'(full), 32'd0);
    tick();
    chk("flush.empty", 32'(commit_en), 32'd0);
    in_en = 1'b1; in_rd = 5'd2; in_ready = 1'b1; in_val = 32'h44;
    tick();
    in_en = 1'b0; in_ready = 1'b0;
    tick();
    chk_commit("flush.head0", 0, 2, 32'h44);

    // asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    chk("arst.commit_en", 32'(commit_en), 32'd0);
    chk("arst.commit_val", commit_val, 32'd0);
    chk("arst.commit_rd", 32'(commit_rd), 32'd0);
    chk("arst.commit_vid", 32'(commit_vregid), 32'd0);
    chk("arst.alloc_id", 32'(alloc_id), 32'd0);
    #1 rst = 1'b0;
    tick();
    chk("arst.after", 32'(commit_en), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have: hci_rdy  in  1  global advance; when low, no state or output register changes.
REQ-004 SHALL have: in_en  in  1  allocate one entry this cycle.
REQ-005 SHALL have: in_rd  in  5  architectural destination register of the allocated instruction.
REQ-006 SHALL have: in_ready  in  1  result already known at allocation, e.g. LUI.
REQ-007 SHALL have: in_val  in  32  result value, valid when in_ready=1.
REQ-008 SHALL have: alloc_id  out  5  vreg id (slot index) that in_en takes this cycle; equals tail pointer.
REQ-009 SHALL have: full  out  1  combinational, high when count>=30.
REQ-010 SHALL have: writebackN_en/vregid/val for N=1,2,3  in  1/5/32  result broadcast buses from the ALU and other reservation stations.
REQ-011 SHALL have: query1_id, query2_id  in  5  operand lookup slots; query1_ready/query2_ready  out  1; query1_val/query2_val  out  32.
REQ-012 SHALL have: flush  in  1  discard all in-flight entries.
REQ-013 SHALL have: commit_en  out  1; commit_rd  out  5; commit_vregid  out  5; commit_val  out  32; all registered.

Function
REQ-014 SHALL hold 32 entries (live, ready, rd, val) in a circular buffer; head, tail 5-bit wrapping; count 6-bit, 0..32.
REQ-015 SHALL, on an edge with hci_rdy=1 and in_en=1, write slot tail with live=1, rd=in_rd, ready=in_ready, val=in_val, then increment tail mod 32.
REQ-016 SHALL, when an allocation in the same cycle matches a writeback vregid equal to alloc_id, leave the entry not ready; stale broadcasts never apply to a freshly allocated slot.
REQ-017 SHALL, on each edge with hci_rdy=1, set ready=1 and val=writebackN_val for every live, not-ready entry whose index equals writebackN_vregid with writebackN_en=1; priority 1>2>3 on duplicate ids.
REQ-018 SHALL commit at most one entry per cycle: if slot head is live and ready at the edge, register commit_en=1, commit_rd, commit_vregid=head, commit_val, clear live[head], increment head; otherwise register commit_en=0.
REQ-019 SHALL not bypass writebacks into commit: minimum latency is writeback edge to commit_en high one cycle later; an in_ready allocation into an empty buffer gives commit_en high after the second edge.
REQ-020 SHALL update count as count + alloc - commit, where alloc and commit are each 0/1 and may occur in the same cycle.
REQ-021 SHALL ignore in_en when count=32; reaching it is a $fatal simulation error, since upstream respects full.
REQ-022 SHALL drive queryK_ready/queryK_val combinationally: entry ready gives stored val; else a matching writebackN_en/vregid gives that bus value with priority 1>2>3 and ready=1; else ready=0, val=0.
REQ-023 SHALL, on an edge with hci_rdy=1 and flush=1, clear all live bits, set head=tail=count=0, and register commit_en=0; flush overrides in_en, writebacks and commit in that cycle.
REQ-024 SHALL hold head, tail, count, entries and commit_* unchanged while hci_rdy=0, whether or not in_en or writebacks are asserted.
REQ-025 SHALL wrap head and tail from 31 to 0 without loss; in_rd=0 entries commit normally, and register-file filtering is downstream.

Reset
REQ-026 SHALL, while rst=1 and regardless of clk, force head=tail=count=0, all live=0, all ready=0, commit_en=0, commit_rd=0, commit_vregid=0, commit_val=0; full=0 follows.
REQ-027 SHALL take rst asserted mid-operation, including during flush or a full buffer, to the same state; entry val/rd contents need no reset.

Verification
REQ-028 SHALL cover in-order commit: allocate rd=5 (not ready, id 0) then rd=6 (in_ready, val 0x22, id 1); writeback2 id0 val 0x11 -> commits 0x11/rd5 then 0x22/rd6 on consecutive cycles, never rd6 first.
REQ-029 SHALL cover query bypass: entry id3 not ready, writeback1_en=1, vregid=3, val 0xDEADBEEF, query1_id=3 in the same cycle -> query1_ready=1, query1_val=0xDEADBEEF combinationally.
REQ-030 SHALL cover full/wrap: allocate 30 without writebacks -> full=1 at count 30; then retire all and allocate 40 more -> tail and head wrap 31->0, alloc_id sequence continuous, all commits in order.
REQ-031 SHALL cover simultaneous events: count=30 with head ready, in_en=1 -> count stays 30, commit_en=1 next cycle, alloc_id advances by one.
REQ-032 SHALL cover stall: hci_rdy=0 for 3 cycles with in_en=1 and writeback3 pulses -> no count, head, tail or commit change; broadcasts during the stall are lost.
REQ-033 SHALL cover flush/reset: 10 live entries, flush=1 -> next cycle count=0, alloc_id=0, commit_en=0; async rst pulse between edges -> outputs zero immediately.
